thread_scheduler: RTL and testbench
===================================

// Module: thread_scheduler
// PURPOSE
//  Round-robin fine-grain thread scheduler for the multithreaded core. Tracks per-thread ready state and
//  picks the active thread id that indexes the per-thread PC storage. Sequences every context switch:
//  saves the outgoing PC, selects the next thread and holds the frontend until it acknowledges the redirect.
// PARAMETERS
//  CVA6Cfg      cva6_cfg_empty      core configuration
//  NUM_THREADS  CVA6Cfg.NUM_THREADS hardware thread count, >=2; TID_W = $clog2(NUM_THREADS)
//  QUANTUM      64                  max RUN cycles before preemption; >=2
// PORTS
//  clk_i            in  1         clock
//  rst_i            in  1         synchronous reset, active-high
//  thread_enable_i  in  NUM_THREADS  per-thread enable (CSR-driven)
//  block_valid_i    in  1         active thread stalls on a long-latency event
//  block_tid_i      in  TID_W     thread id being blocked
//  wake_i           in  NUM_THREADS  per-thread wake pulse (miss return)
//  switch_ack_i     in  1         frontend has flushed and applied the redirect
//  active_valid_o   out 1         a thread is running
//  active_tid_o     out TID_W     running thread id (PC read index)
//  switch_req_o     out 1         context switch in progress; frontend must flush
//  save_valid_o     out 1         write outgoing PC into slot save_tid_o this switch
//  save_tid_o       out TID_W     outgoing thread id
//  next_valid_o     out 1         a next thread exists; next_tid_o is valid
//  next_tid_o       out TID_W     incoming thread id
//  switch_count_o   out 32        completed switches (THREAD_SCHED_PERF_EN only)
// BEHAVIOUR
//  - ready[i] = thread_enable_i[i] & ~blocked[i]. blocked[i] set on block_valid_i && block_tid_i==i, cleared
//    by wake_i[i]. Wake and block on the same thread in the same cycle: wake wins, blocked[i]=0.
//  - Reset: state=IDLE, blocked=0, active_tid_o=0, active_valid_o=0, all other outputs 0, quantum=0, rr_ptr=0.
//  - Pick: first ready thread searching from (rr_ptr+1) mod NUM_THREADS, wrapping, excluding active_tid_o in RUN.
//  - FSM: IDLE, RUN, SWITCH.
//    IDLE: active_valid_o=0. Any ready thread -> SWITCH with save_valid=0, next=pick (searching from rr_ptr).
//    RUN: quantum++ each cycle, saturating at QUANTUM-1. Go to SWITCH with save_valid=1, save_tid=active, when
//      (a) current not ready (blocked this cycle or disabled), or (b) quantum==QUANTUM-1 and another thread is ready.
//      When (a) fires and no other thread is ready: next_valid=0. When (b) fires and no other thread is ready: stay RUN.
//    SWITCH: switch_req_o=1; save/next fields registered on entry, held stable until ack. active_valid_o=0.
//      On switch_ack_i: if next_valid: active_tid_o<=next_tid, rr_ptr<=next_tid, quantum<=0 -> RUN;
//      otherwise -> IDLE. Changes to ready during SWITCH do not alter the latched next; an incoming thread that has
//      since blocked is re-handled from RUN on the next cycle.
//  - Latency: trigger cycle T -> switch_req_o high at T+1; ack at cycle A -> active_valid_o high at A+1.
//  - switch_ack_i outside SWITCH is ignored. block_valid_i with block_tid_i != active still sets blocked.
//  - rst_i mid-SWITCH aborts immediately to the reset values; no save is performed.
// CONFIGURATION
//  THREAD_SCHED_PERF_EN defined: switch_count_o increments by 1 on every ack in SWITCH with next_valid=1,
//    wraps at 2^32, cleared by reset.
//  Undefined: counter not built; switch_count_o tied to 0.
// TESTING
//  1 NUM_THREADS=4, enable=4'b0001, reset release -> SWITCH, save_valid=0, next_tid=0; ack -> RUN, tid 0.
//  2 enable=4'b1111, no blocks, QUANTUM=8 -> switches every 8 RUN cycles (+ack latency); tid order 0,1,2,3,0.
//  3 Running tid 1, block_valid_i with tid 1, threads 2,3 disabled, thread 0 ready -> save_tid=1, next_tid=0.
//  4 Only tid 2 enabled, block tid 2 -> SWITCH next_valid=0, ack -> IDLE; wake_i[2] -> SWITCH, save_valid=0, next=2.
//  5 Block and wake of tid 3 in the same cycle -> blocked[3]=0; tid 3 stays RUN.
//  6 rst_i asserted while switch_req_o=1 -> next cycle all outputs at reset values; PERF build: switch_count_o=0.

Source files
------------

// File: rtl/thread_scheduler.sv
// Round-robin fine-grain thread scheduler: tracks per-thread ready state and sequences context switches.
// Optional switch counter built when THREAD_SCHED_PERF_EN is defined; otherwise switch_count_o is tied to 0.
module thread_scheduler #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned QUANTUM     = 64,
  localparam int unsigned TID_W      = $clog2(NUM_THREADS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_THREADS-1:0] thread_enable_i,
  input  logic                   block_valid_i,
  input  logic [TID_W-1:0]       block_tid_i,
  input  logic [NUM_THREADS-1:0] wake_i,
  input  logic                   switch_ack_i,
  output logic                   active_valid_o,
  output logic [TID_W-1:0]       active_tid_o,
  output logic                   switch_req_o,
  output logic                   save_valid_o,
  output logic [TID_W-1:0]       save_tid_o,
  output logic                   next_valid_o,
  output logic [TID_W-1:0]       next_tid_o,
  output logic [31:0]            switch_count_o
);

  localparam int unsigned QW = (QUANTUM > 2) ? $clog2(QUANTUM) : 1;
  localparam logic [QW-1:0] QMAX = QW'(QUANTUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SWITCH} state_t;

  state_t                 r_state, w_state_nxt;
  logic [NUM_THREADS-1:0] r_blocked, w_blocked_nxt, w_ready;
  logic [TID_W-1:0]       r_rr_ptr, w_rr_nxt;
  logic [QW-1:0]          r_quantum, w_quantum_nxt;
  logic [TID_W-1:0]       r_active_tid, w_active_tid_nxt;
  logic                   r_active_valid, r_switch_req;
  logic                   r_save_valid, w_save_valid_nxt;
  logic [TID_W-1:0]       r_save_tid, w_save_tid_nxt;
  logic                   r_next_valid, w_next_valid_nxt;
  logic [TID_W-1:0]       r_next_tid, w_next_tid_nxt;
  logic                   w_pick_found;
  logic [TID_W-1:0]       w_pick_tid;

  // Wake beats a same-cycle block; ready reflects this cycle's block/wake events
  always_comb begin
    for (int i = 0; i < int'(NUM_THREADS); i++) begin
      if (wake_i[i])                                              w_blocked_nxt[i] = 1'b0;
      else if (block_valid_i && (block_tid_i == TID_W'(i)))       w_blocked_nxt[i] = 1'b1;
      else                                                        w_blocked_nxt[i] = r_blocked[i];
    end
    w_ready = thread_enable_i & ~w_blocked_nxt;
  end

  // IDLE searches from rr_ptr inclusive; RUN starts after rr_ptr and skips the active thread
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_tid   = '0;
    for (int unsigned k = 0; k < NUM_THREADS; k++) begin
      int unsigned s;
      s = 32'(r_rr_ptr) + ((r_state == S_RUN) ? 32'd1 : 32'd0) + k;
      if (s >= NUM_THREADS) s = s - NUM_THREADS;
      if (!w_pick_found && w_ready[TID_W'(s)] &&
          !((r_state == S_RUN) && (TID_W'(s) == r_active_tid))) begin
        w_pick_found = 1'b1;
        w_pick_tid   = TID_W'(s);
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_rr_nxt         = r_rr_ptr;
    w_quantum_nxt    = r_quantum;
    w_active_tid_nxt = r_active_tid;
    w_save_valid_nxt = r_save_valid;
    w_save_tid_nxt   = r_save_tid;
    w_next_valid_nxt = r_next_valid;
    w_next_tid_nxt   = r_next_tid;
    case (r_state)
      S_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt      = S_SWITCH;
          w_save_valid_nxt = 1'b0;
          w_save_tid_nxt   = '0;
          w_next_valid_nxt = 1'b1;
          w_next_tid_nxt   = w_pick_tid;
        end
      end
      S_RUN: begin
        if (r_quantum != QMAX) w_quantum_nxt = r_quantum + QW'(1);
        if (!w_ready[r_active_tid] || ((r_quantum == QMAX) && w_pick_found)) begin
          w_state_nxt      = S_SWITCH;
          w_save_valid_nxt = 1'b1;
          w_save_tid_nxt   = r_active_tid;
          w_next_valid_nxt = w_pick_found;
          w_next_tid_nxt   = w_pick_found ? w_pick_tid : '0;
        end
      end
      S_SWITCH: begin
        if (switch_ack_i) begin
          if (r_next_valid) begin
            w_state_nxt      = S_RUN;
            w_active_tid_nxt = r_next_tid;
            w_rr_nxt         = r_next_tid;
            w_quantum_nxt    = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
          w_save_valid_nxt = 1'b0;
          w_save_tid_nxt   = '0;
          w_next_valid_nxt = 1'b0;
          w_next_tid_nxt   = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= S_IDLE;
      r_blocked      <= '0;
      r_rr_ptr       <= '0;
      r_quantum      <= '0;
      r_active_tid   <= '0;
      r_active_valid <= 1'b0;
      r_switch_req   <= 1'b0;
      r_save_valid   <= 1'b0;
      r_save_tid     <= '0;
      r_next_valid   <= 1'b0;
      r_next_tid     <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_blocked      <= w_blocked_nxt;
      r_rr_ptr       <= w_rr_nxt;
      r_quantum      <= w_quantum_nxt;
      r_active_tid   <= w_active_tid_nxt;
      r_active_valid <= (w_state_nxt == S_RUN);
      r_switch_req   <= (w_state_nxt == S_SWITCH);
      r_save_valid   <= w_save_valid_nxt;
      r_save_tid     <= w_save_tid_nxt;
      r_next_valid   <= w_next_valid_nxt;
      r_next_tid     <= w_next_tid_nxt;
    end
  end

  assign active_valid_o = r_active_valid;
  assign active_tid_o   = r_active_tid;
  assign switch_req_o   = r_switch_req;
  assign save_valid_o   = r_save_valid;
  assign save_tid_o     = r_save_tid;
  assign next_valid_o   = r_next_valid;
  assign next_tid_o     = r_next_tid;

`ifdef THREAD_SCHED_PERF_EN
  logic [31:0] r_switch_count;

  // Counts only switches that hand the core to a new thread
  always_ff @(posedge clk_i) begin
    if (rst_i)                                                     r_switch_count <= '0;
    else if ((r_state == S_SWITCH) && switch_ack_i && r_next_valid) r_switch_count <= r_switch_count + 32'd1;
  end

  assign switch_count_o = r_switch_count;
`else
  assign switch_count_o = '0;
`endif

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed bench for thread_scheduler (4 threads, quantum 8); honours THREAD_SCHED_PERF_EN for the counter.
module tb_thread_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] en;
  logic       bv;
  logic [1:0] btid;
  logic [3:0] wake;
  logic       ack;
  logic       av, sr, sv, nv;
  logic [1:0] atid, stid, ntid;
  logic [31:0] cnt;
  logic [9:0] obs, e;
  logic [31:0] ecnt;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  thread_scheduler #(.NUM_THREADS(4), .QUANTUM(8)) dut (
    .clk_i(clk), .rst_i(rst), .thread_enable_i(en), .block_valid_i(bv), .block_tid_i(btid),
    .wake_i(wake), .switch_ack_i(ack), .active_valid_o(av), .active_tid_o(atid),
    .switch_req_o(sr), .save_valid_o(sv), .save_tid_o(stid), .next_valid_o(nv),
    .next_tid_o(ntid), .switch_count_o(cnt)
  );

  assign obs = {av, atid, sr, sv, stid, nv, ntid};

  function automatic logic [9:0] mkv(input logic a, input logic [1:0] t, input logic r,
                                     input logic s, input logic [1:0] st, input logic n,
                                     input logic [1:0] nt);
    return {a, t, r, s, st, n, nt};
  endfunction

  function automatic logic [31:0] perf(input int unsigned n);
`ifdef THREAD_SCHED_PERF_EN
    return 32'(n);
`else
    return 32'(n) & 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_reset(input logic [3:0] enable);
    rst = 1'b1; en = enable; bv = 1'b0; btid = 2'd0; wake = 4'd0; ack = 1'b0;
    tick(); tick();
    e = 10'd0;
    if (obs !== e) begin $display("FAIL reset_outputs: got %b expected %b", obs, e); failures++; end
    checks++;
    if (cnt !== 32'd0) begin $display("FAIL reset_count: got %0d expected 0", cnt); failures++; end
    checks++;
    rst = 1'b0;
  endtask

  task automatic test_single_thread_start();
    test_reset(4'b0001);
    tick();
    e = mkv(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0);
    if (obs !== e) begin $display("FAIL start_switch: got %b expected %b", obs, e); failures++; end
    checks++;
    ack_pulse();
    e = mkv(1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    if (obs !== e) begin $display("FAIL start_run: got %b expected %b", obs, e); failures++; end
    checks++;
    ecnt = perf(1);
    if (cnt !== ecnt) begin $display("FAIL start_count: got %0d expected %0d", cnt, ecnt); failures++; end
    checks++;
  endtask

  task automatic test_round_robin();
    logic [1:0] t;
    test_reset(4'b1111);
    tick();
    e = mkv(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0);
    if (obs !== e) begin $display("FAIL rr_first_switch: got %b expected %b", obs, e); failures++; end
    checks++;
    for (int i = 0; i < 5; i++) begin
      t = 2'(i % 4);
      ack_pulse();
      e = mkv(1'b1, t, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
      if (obs !== e) begin $display("FAIL rr_run%0d: got %b expected %b", i, obs, e); failures++; end
      checks++;
      if (i < 4) begin
        repeat (7) tick();
        if (sr !== 1'b0) begin $display("FAIL rr_early%0d: switch_req got %b expected 0", i, sr); failures++; end
        checks++;
        tick();
        e = mkv(1'b0, t, 1'b1, 1'b1, t, 1'b1, 2'(t + 2'd1));
        if (obs !== e) begin $display("FAIL rr_preempt%0d: got %b expected %b", i, obs, e); failures++; end
        checks++;
      end
    end
    ecnt = perf(5);
    if (cnt !== ecnt) begin $display("FAIL rr_count: got %0d expected %0d", cnt, ecnt); failures++; end
    checks++;
  endtask

  task automatic test_block_switch();
    test_reset(4'b0011);
    tick(); ack_pulse();
    repeat (8) tick();
    e = mkv(1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 1'b1, 2'd1);
    if (obs !== e) begin $display("FAIL blk_preempt: got %b expected %b", obs, e); failures++; end
    checks++;
    ack_pulse();
    bv = 1'b1; btid = 2'd1; tick(); bv = 1'b0;
    e = mkv(1'b0, 2'd1, 1'b1, 1'b1, 2'd1, 1'b1, 2'd0);
    if (obs !== e) begin $display("FAIL blk_switch: got %b expected %b", obs, e); failures++; end
    checks++;
  endtask

  task automatic test_idle_wake();
    test_reset(4'b0100);
    tick();
    e = mkv(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2);
    if (obs !== e) begin $display("FAIL idle_first: got %b expected %b", obs, e); failures++; end
    checks++;
    ack_pulse();
    bv = 1'b1; btid = 2'd2; tick(); bv = 1'b0;
    e = mkv(1'b0, 2'd2, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0);
    if (obs !== e) begin $display("FAIL idle_nonext: got %b expected %b", obs, e); failures++; end
    checks++;
    ack_pulse();
    repeat (3) tick();
    e = mkv(1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    if (obs !== e) begin $display("FAIL idle_state: got %b expected %b", obs, e); failures++; end
    checks++;
    wake = 4'b0100; tick(); wake = 4'd0;
    e = mkv(1'b0, 2'd2, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2);
    if (obs !== e) begin $display("FAIL idle_wake: got %b expected %b", obs, e); failures++; end
    checks++;
  endtask

  task automatic test_block_wake_same_cycle();
    test_reset(4'b1000);
    tick(); ack_pulse();
    repeat (12) tick();
    e = mkv(1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    if (obs !== e) begin $display("FAIL bw_saturate: got %b expected %b", obs, e); failures++; end
    checks++;
    ack_pulse();
    if (obs !== e) begin $display("FAIL bw_stray_ack: got %b expected %b", obs, e); failures++; end
    checks++;
    bv = 1'b1; btid = 2'd3; wake = 4'b1000; tick(); bv = 1'b0; wake = 4'd0;
    repeat (2) tick();
    if (obs !== e) begin $display("FAIL bw_same_cycle: got %b expected %b", obs, e); failures++; end
    checks++;
  endtask

  task automatic test_reset_mid_switch();
    bv = 1'b1; btid = 2'd3; tick(); bv = 1'b0;
    e = mkv(1'b0, 2'd3, 1'b1, 1'b1, 2'd3, 1'b0, 2'd0);
    if (obs !== e) begin $display("FAIL rst_pre: got %b expected %b", obs, e); failures++; end
    checks++;
    ecnt = perf(1);
    if (cnt !== ecnt) begin $display("FAIL rst_pre_count: got %0d expected %0d", cnt, ecnt); failures++; end
    checks++;
    rst = 1'b1; tick();
    e = 10'd0;
    if (obs !== e) begin $display("FAIL rst_mid_switch: got %b expected %b", obs, e); failures++; end
    checks++;
    if (cnt !== 32'd0) begin $display("FAIL rst_mid_count: got %0d expected 0", cnt); failures++; end
    checks++;
    rst = 1'b0;
  endtask

  initial begin
    test_single_thread_start();
    test_round_robin();
    test_block_switch();
    test_idle_wake();
    test_block_wake_same_cycle();
    test_reset_mid_switch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
